// File: rtl/fetcher_iq.sv
// fetcher_iq: instruction fetch stage with an IQ_DEPTH-entry instruction queue.
//   Fetches from the icache at pc, probes the branch predictor on every hit,
//   and pushes {inst, pc, alternate target, prediction} into a FIFO that the
//   decoder drains with valid/ready. ROB rollback flushes the queue and
//   redirects pc, costing one bubble cycle. A fetched JALR parks the fetcher
//   until the next rollback supplies the real target.
// Ports:
//   clk, rst (async, active-low), rdy (0 freezes all state)
//   if_en, if_rb, rob_rb_pc           : fetch enable / rollback from ROB
//   cache_rd_en/addr, cache_hit/_inst : icache interface
//   bp_pb_pc/inst, bp_pd_tk/off       : branch predictor probe / response
//   id_ready, id_valid, id_inst, id_cur_pc, id_mis_pc, id_pd_tk : decoder side
//   iq_count                          : queue occupancy
// Optional: define FETCH_PERF_EN to add perf_fetch_cnt / perf_stall_cnt.
module fetcher_iq #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                IQ_DEPTH = 4,
    parameter int                PC_INC   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      if_en,
    input  logic                      if_rb,
    input  logic [ADDR_W-1:0]         rob_rb_pc,
    output logic                      cache_rd_en,
    output logic [ADDR_W-1:0]         cache_rd_addr,
    input  logic                      cache_hit,
    input  logic [INST_W-1:0]         cache_hit_inst,
    output logic [ADDR_W-1:0]         bp_pb_pc,
    output logic [INST_W-1:0]         bp_pb_inst,
    input  logic                      bp_pd_tk,
    input  logic [ADDR_W-1:0]         bp_pd_off,
    input  logic                      id_ready,
    output logic                      id_valid,
    output logic [INST_W-1:0]         id_inst,
    output logic [ADDR_W-1:0]         id_cur_pc,
    output logic [ADDR_W-1:0]         id_mis_pc,
    output logic                      id_pd_tk,
`ifdef FETCH_PERF_EN
    output logic [31:0]               perf_fetch_cnt,
    output logic [31:0]               perf_stall_cnt,
`endif
    output logic [$clog2(IQ_DEPTH):0] iq_count
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, REDIRECT, JALR_WAIT} state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] mis;
        logic              tk;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    entry_t            hent_q, hent_d;
    entry_t            mem_q [IQ_DEPTH];

    logic [ADDR_W-1:0] jump, succ;
    entry_t            new_ent;
    logic              enq, deq, is_jalr;

    assign jump    = pc_q + bp_pd_off;
    assign succ    = pc_q + ADDR_W'(PC_INC);
    assign new_ent = '{inst: cache_hit_inst, pc: pc_q,
                       mis: bp_pd_tk ? succ : jump, tk: bp_pd_tk};
    assign is_jalr = (cache_hit_inst[6:0] == 7'b1100111);

    assign enq = (state_q == RUN) && if_en && cache_hit &&
                 (cache_hit_inst != '0) && !full_q && !if_rb;
    assign deq = (count_q != '0) && id_ready && !if_rb;

    assign cache_rd_en   = (state_q == RUN) && if_en && !full_q;
    assign cache_rd_addr = pc_q;
    assign bp_pb_pc      = pc_q;
    assign bp_pb_inst    = cache_hit_inst;
    assign id_valid      = (count_q != '0);
    assign id_inst       = hent_q.inst;
    assign id_cur_pc     = hent_q.pc;
    assign id_mis_pc     = hent_q.mis;
    assign id_pd_tk      = hent_q.tk;
    assign iq_count      = count_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        hent_d  = hent_q;
        if (if_rb) begin
            state_d = REDIRECT;
            pc_d    = rob_rb_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq) head_d = head_q + 1'b1;
            if (enq) begin
                tail_d = tail_q + 1'b1;
                pc_d   = bp_pd_tk ? jump : succ;
            end
            count_d = count_q + CW'(enq) - CW'(deq);
            if (state_q == REDIRECT) state_d = RUN;
            else if (enq && is_jalr) state_d = JALR_WAIT;
            // Registered head view: the entry being written this edge is the
            // new head when it lands on the slot head_d points to.
            if (count_d != '0)
                hent_d = (enq && head_d == tail_q) ? new_ent : mem_q[head_d];
        end
        full_d = (count_d == CW'(IQ_DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            hent_q  <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            hent_q  <= hent_d;
        end
    end

    // Payload storage carries no reset; slots are only read once written.
    always_ff @(posedge clk) begin
        if (rdy && enq) mem_q[tail_q] <= new_ent;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] pf_q, ps_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pf_q <= '0;
            ps_q <= '0;
        end else if (rdy) begin
            if (enq) pf_q <= pf_q + 32'd1;
            if (if_en && (full_q || state_q != RUN || !cache_hit))
                ps_q <= ps_q + 32'd1;
        end
    end
    assign perf_fetch_cnt = pf_q;
    assign perf_stall_cnt = ps_q;
`endif

endmodule

// File: tb/tb_fetcher_iq.sv
module tb_fetcher_iq;
    localparam int DEPTH = 4;

    logic        clk, rst, rdy, if_en, if_rb, cache_rd_en, cache_hit;
    logic [31:0] rob_rb_pc, cache_rd_addr, cache_hit_inst, bp_pb_pc, bp_pb_inst;
    logic        bp_pd_tk, id_ready, id_valid, id_pd_tk;
    logic [31:0] bp_pd_off, id_inst, id_cur_pc, id_mis_pc;
    logic [2:0]  iq_count;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    fetcher_iq #(.IQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .if_en(if_en), .if_rb(if_rb),
        .rob_rb_pc(rob_rb_pc), .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr),
        .cache_hit(cache_hit), .cache_hit_inst(cache_hit_inst),
        .bp_pb_pc(bp_pb_pc), .bp_pb_inst(bp_pb_inst),
        .bp_pd_tk(bp_pd_tk), .bp_pd_off(bp_pd_off),
        .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst),
        .id_cur_pc(id_cur_pc), .id_mis_pc(id_mis_pc), .id_pd_tk(id_pd_tk),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .iq_count(iq_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Reference model: a plain queue of fetched entries plus a mode flag.
    typedef struct {logic [31:0] inst, pc, mis; logic tk;} ent_t;
    ent_t        m_q[$];
    ent_t        m_last;
    logic [31:0] m_pc;
    int          m_mode;   // 0 fetching, 1 bubble after rollback, 2 parked on JALR
    logic [31:0] m_fetch, m_stall;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last  = '{0, 0, 0, 1'b0};
        m_pc    = 32'h0;
        m_mode  = 0;
        m_fetch = 0;
        m_stall = 0;
    endtask

    // Applies the fetch rules for one rdy edge using the current inputs.
    task automatic model_step();
        bit   can_fetch, take;
        ent_t e;
        if (!rdy) return;
        if (if_en && (m_q.size() == DEPTH || m_mode != 0 || !cache_hit)) m_stall++;
        if (if_rb) begin
            m_q.delete();
            m_pc   = rob_rb_pc;
            m_mode = 1;
            return;
        end
        can_fetch = (m_mode == 0) && if_en && cache_hit && cache_hit_inst != 0 &&
                    m_q.size() < DEPTH;
        take = (m_q.size() > 0) && id_ready;
        if (take) void'(m_q.pop_front());
        if (m_mode == 1) m_mode = 0;
        if (can_fetch) begin
            e.inst = cache_hit_inst;
            e.pc   = m_pc;
            e.tk   = bp_pd_tk;
            e.mis  = bp_pd_tk ? m_pc + 4 : m_pc + bp_pd_off;
            m_q.push_back(e);
            m_pc = bp_pd_tk ? m_pc + bp_pd_off : m_pc + 4;
            m_fetch++;
            if (cache_hit_inst[6:0] == 7'b1100111) m_mode = 2;
        end
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    task automatic do_reset();
        rst = 1'b0; rdy = 1'b1; if_en = 1'b0; if_rb = 1'b0; rob_rb_pc = 0;
        cache_hit = 1'b0; cache_hit_inst = 0; bp_pd_tk = 1'b0; bp_pd_off = 0;
        id_ready = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (iq_count !== 3'd0)     begin n_fail++; $display("FAIL reset_count got %0d want 0", iq_count); end
        n_chk++; if (id_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_valid got %b want 0", id_valid); end
        n_chk++; if (cache_rd_addr !== 0)   begin n_fail++; $display("FAIL reset_pc got %h want 0", cache_rd_addr); end
        n_chk++; if ({id_inst, id_cur_pc, id_mis_pc, id_pd_tk} !== '0)
                                            begin n_fail++; $display("FAIL reset_id got %h/%h/%h/%b want 0", id_inst, id_cur_pc, id_mis_pc, id_pd_tk); end
`ifdef FETCH_PERF_EN
        n_chk++; if (perf_fetch_cnt !== 0 || perf_stall_cnt !== 0)
                                            begin n_fail++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
    endtask

    task automatic test_sequential();
        do_reset();
        if_en = 1; id_ready = 1; cache_hit = 1; cache_hit_inst = 32'h13; bp_pd_off = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (id_valid !== 1'b1 || id_cur_pc !== 32'(4*i) || id_mis_pc !== 32'(4*i + 8) || iq_count > 1)
                begin n_fail++; $display("FAIL seq_%0d got v=%b pc=%h mis=%h cnt=%0d want v=1 pc=%h mis=%h cnt<=1",
                                         i, id_valid, id_cur_pc, id_mis_pc, iq_count, 4*i, 4*i + 8); end
        end
    endtask

    task automatic test_taken();
        do_reset();
        if_en = 1; id_ready = 1; cache_hit = 1; cache_hit_inst = 32'h13;
        for (int i = 0; i < 4; i++) tick();        // pc 0 -> 0x10
        bp_pd_tk = 1; bp_pd_off = 32'h20;
        tick();
        n_chk++; if (cache_rd_addr !== 32'h30) begin n_fail++; $display("FAIL taken_pc got %h want 30", cache_rd_addr); end
        n_chk++; if (id_cur_pc !== 32'h10 || id_mis_pc !== 32'h14 || id_pd_tk !== 1'b1)
            begin n_fail++; $display("FAIL taken_entry got pc=%h mis=%h tk=%b want 10/14/1", id_cur_pc, id_mis_pc, id_pd_tk); end
    endtask

    task automatic test_backpressure();
        do_reset();
        if_en = 1; cache_hit = 1; cache_hit_inst = 32'h13;
        for (int i = 0; i < 6; i++) tick();
        n_chk++; if (iq_count !== 3'd4 || cache_rd_en !== 1'b0 || cache_rd_addr !== 32'h10)
            begin n_fail++; $display("FAIL bp_full got cnt=%0d en=%b pc=%h want 4/0/10", iq_count, cache_rd_en, cache_rd_addr); end
        if_en = 0; id_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (id_valid !== 1'b1 || id_cur_pc !== 32'(4*i))
                begin n_fail++; $display("FAIL bp_drain_%0d got v=%b pc=%h want 1/%h", i, id_valid, id_cur_pc, 4*i); end
            tick();
        end
        n_chk++; if (id_valid !== 1'b0 || iq_count !== 3'd0)
            begin n_fail++; $display("FAIL bp_empty got v=%b cnt=%0d want 0/0", id_valid, iq_count); end
    endtask

    task automatic test_rollback();
        do_reset();
        if_en = 1; cache_hit = 1; cache_hit_inst = 32'h13;
        for (int i = 0; i < 3; i++) tick();
        n_chk++; if (iq_count !== 3'd3) begin n_fail++; $display("FAIL rb_fill got %0d want 3", iq_count); end
        if_rb = 1; rob_rb_pc = 32'h100; id_ready = 1;
        tick();
        if_rb = 0;
        n_chk++; if (iq_count !== 3'd0 || id_valid !== 1'b0 || cache_rd_en !== 1'b0)
            begin n_fail++; $display("FAIL rb_flush got cnt=%0d v=%b en=%b want 0/0/0", iq_count, id_valid, cache_rd_en); end
        tick();
        n_chk++; if (cache_rd_addr !== 32'h100 || cache_rd_en !== 1'b1)
            begin n_fail++; $display("FAIL rb_resume got pc=%h en=%b want 100/1", cache_rd_addr, cache_rd_en); end
    endtask

    task automatic test_jalr();
        do_reset();
        if_en = 1; if_rb = 1; rob_rb_pc = 32'h40;
        tick(); if_rb = 0; tick();
        cache_hit = 1; cache_hit_inst = 32'h000080E7; id_ready = 1;
        tick();
        n_chk++; if (id_valid !== 1'b1 || id_inst !== 32'h80E7 || id_cur_pc !== 32'h40)
            begin n_fail++; $display("FAIL jalr_enq got v=%b inst=%h pc=%h want 1/80e7/40", id_valid, id_inst, id_cur_pc); end
        for (int i = 0; i < 10; i++) begin
            n_chk++; if (cache_rd_en !== 1'b0) begin n_fail++; $display("FAIL jalr_hold_%0d got en=%b want 0", i, cache_rd_en); end
            tick();
        end
        n_chk++; if (iq_count !== 3'd0) begin n_fail++; $display("FAIL jalr_drain got %0d want 0", iq_count); end
        if_rb = 1; rob_rb_pc = 32'h200;
        tick(); if_rb = 0;
        n_chk++; if (cache_rd_en !== 1'b0) begin n_fail++; $display("FAIL jalr_bubble got en=%b want 0", cache_rd_en); end
        tick();
        n_chk++; if (cache_rd_en !== 1'b1 || cache_rd_addr !== 32'h200)
            begin n_fail++; $display("FAIL jalr_resume got en=%b pc=%h want 1/200", cache_rd_en, cache_rd_addr); end
    endtask

    task automatic test_async_reset_rdy();
        do_reset();
        if_en = 1; cache_hit = 1; cache_hit_inst = 32'h13;
        tick(); tick();
        #2 rst = 0; #1;
        n_chk++; if (iq_count !== 3'd0 || id_valid !== 1'b0 || cache_rd_addr !== 32'h0)
            begin n_fail++; $display("FAIL async_rst got cnt=%0d v=%b pc=%h want 0/0/0", iq_count, id_valid, cache_rd_addr); end
`ifdef FETCH_PERF_EN
        n_chk++; if (perf_fetch_cnt !== 0 || perf_stall_cnt !== 0)
            begin n_fail++; $display("FAIL async_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
        tick(); rst = 1;
        tick(); tick();
        rdy = 0; id_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (iq_count !== 3'd2 || cache_rd_addr !== 32'h8 || id_cur_pc !== 32'h0)
                begin n_fail++; $display("FAIL rdy_hold_%0d got cnt=%0d pc=%h head=%h want 2/8/0", i, iq_count, cache_rd_addr, id_cur_pc); end
        end
        rdy = 1;
    endtask

    task automatic test_random();
        logic [31:0] v;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            if_en     = ($urandom_range(0, 7) != 0);
            if_rb     = ($urandom_range(0, 11) == 0);
            rob_rb_pc = $urandom;
            cache_hit = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 9))
                0:       cache_hit_inst = 32'h0;
                1:       cache_hit_inst = 32'h000080E7;
                default: begin v = $urandom; v[6:0] = 7'h33; cache_hit_inst = v; end
            endcase
            bp_pd_tk  = $urandom_range(0, 1);
            bp_pd_off = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63)) << 2;
            id_ready  = ($urandom_range(0, 2) != 0);
            #1;
            n_chk++; if (cache_rd_en !== (m_mode == 0 && if_en && m_q.size() < DEPTH) || cache_rd_addr !== m_pc ||
                         bp_pb_pc !== m_pc || bp_pb_inst !== cache_hit_inst)
                begin n_fail++; $display("FAIL rnd_fetch c=%0d got en=%b pc=%h want mode=%0d pc=%h", c, cache_rd_en, cache_rd_addr, m_mode, m_pc); end
            n_chk++; if (id_valid !== (m_q.size() > 0) || iq_count !== 3'(m_q.size()))
                begin n_fail++; $display("FAIL rnd_count c=%0d got v=%b cnt=%0d want cnt=%0d", c, id_valid, iq_count, m_q.size()); end
            n_chk++; if (id_inst !== m_last.inst || id_cur_pc !== m_last.pc || id_mis_pc !== m_last.mis || id_pd_tk !== m_last.tk)
                begin n_fail++; $display("FAIL rnd_head c=%0d got %h/%h/%h/%b want %h/%h/%h/%b", c, id_inst, id_cur_pc, id_mis_pc,
                                         id_pd_tk, m_last.inst, m_last.pc, m_last.mis, m_last.tk); end
            model_step();
            tick();
        end
`ifdef FETCH_PERF_EN
        n_chk++; if (perf_fetch_cnt !== m_fetch || perf_stall_cnt !== m_stall)
            begin n_fail++; $display("FAIL rnd_perf got %0d/%0d want %0d/%0d", perf_fetch_cnt, perf_stall_cnt, m_fetch, m_stall); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_taken();
        test_backpressure();
        test_rollback();
        test_jalr();
        test_async_reset_rdy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
